// File: rtl/handshake_constant_seq.sv
// Registered burst source: each accepted control token emits REPEAT beats CONST_VALUE, +STEP, ...
// Latency 1 from ctrl acceptance to first beat; outputs hold while outs_ready is low, ctrl_ready low until the last beat leaves.
module handshake_constant_seq #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] STEP        = '0,
    parameter int                    REPEAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);
    localparam int CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REPEAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q;
    logic                    last;
    logic                    fire_o;
    logic                    fire_c;

    assign valid_q    = (state_q == EMIT);
    assign last       = (cnt_q == LAST_CNT);
    assign outs       = data_q;
    assign outs_valid = valid_q;
    assign outs_last  = valid_q && last;
    // Only combinational path: lets a new burst reload on the same edge the last beat leaves.
    assign ctrl_ready = !valid_q || (outs_ready && last);
    assign fire_o     = valid_q && outs_ready;
    assign fire_c     = ctrl_valid && ctrl_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (fire_c) begin
            state_d = EMIT;
            data_d  = CONST_VALUE;
            cnt_d   = '0;
        end else if (fire_o) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                data_d = data_q + STEP;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed bench for handshake_constant_seq across three parameter sets plus a random REPEAT=1 run.
module tb_handshake_constant_seq;
    localparam logic [16:0] C1 = 17'h1EFF2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u1: DATA_WIDTH=17, REPEAT=1
    logic        c1_valid = 1'b0, c1_ready, o1_valid, o1_ready = 1'b0, o1_last;
    logic [16:0] o1_outs;
    // u2: DATA_WIDTH=8, FE step 1, REPEAT=4
    logic        c2_valid = 1'b0, c2_ready, o2_valid, o2_ready = 1'b0, o2_last;
    logic [7:0]  o2_outs;
    // u4: DATA_WIDTH=8, 10 step 3, REPEAT=3
    logic        c4_valid = 1'b0, c4_ready, o4_valid, o4_ready = 1'b0, o4_last;
    logic [7:0]  o4_outs;

    handshake_constant_seq #(.DATA_WIDTH(17), .CONST_VALUE(C1), .STEP(17'd0), .REPEAT(1)) u1 (
        .clk(clk), .rst(rst), .ctrl_valid(c1_valid), .ctrl_ready(c1_ready),
        .outs(o1_outs), .outs_valid(o1_valid), .outs_ready(o1_ready), .outs_last(o1_last));
    handshake_constant_seq #(.DATA_WIDTH(8), .CONST_VALUE(8'hFE), .STEP(8'd1), .REPEAT(4)) u2 (
        .clk(clk), .rst(rst), .ctrl_valid(c2_valid), .ctrl_ready(c2_ready),
        .outs(o2_outs), .outs_valid(o2_valid), .outs_ready(o2_ready), .outs_last(o2_last));
    handshake_constant_seq #(.DATA_WIDTH(8), .CONST_VALUE(8'h10), .STEP(8'd3), .REPEAT(3)) u4 (
        .clk(clk), .rst(rst), .ctrl_valid(c4_valid), .ctrl_ready(c4_ready),
        .outs(o4_outs), .outs_valid(o4_valid), .outs_ready(o4_ready), .outs_last(o4_last));

    logic [7:0] exp2 [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // Beat / token counters for the stall and random scenarios
    logic mon4 = 1'b0, mon6 = 1'b0;
    int beats4 = 0, acc6 = 0, beats6 = 0, bad6 = 0;
    always @(posedge clk) begin
        if (mon4 && o4_valid && o4_ready) beats4 <= beats4 + 1;
        if (mon6 && c1_valid && c1_ready) acc6 <= acc6 + 1;
        if (mon6 && o1_valid && o1_ready) begin
            beats6 <= beats6 + 1;
            if (o1_outs !== C1) bad6 <= bad6 + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (o1_valid !== 1'b0 || o1_outs !== 17'h0 || o1_last !== 1'b0) begin n_fail++; $display("FAIL reset_u1 got v=%b d=%h l=%b want 0 0 0", o1_valid, o1_outs, o1_last); end
        n_checks++; if (o2_valid !== 1'b0 || o2_outs !== 8'h0 || o2_last !== 1'b0) begin n_fail++; $display("FAIL reset_u2 got v=%b d=%h l=%b want 0 0 0", o2_valid, o2_outs, o2_last); end
        n_checks++; if (c4_ready !== 1'b1 || o4_valid !== 1'b0) begin n_fail++; $display("FAIL reset_u4 got rdy=%b v=%b want 1 0", c4_ready, o4_valid); end
        step; step;
        rst = 1'b0;
        step;
    endtask

    task automatic test_single;
        c1_valid = 1'b1; o1_ready = 1'b1;
        n_checks++; if (c1_ready !== 1'b1) begin n_fail++; $display("FAIL t1_idle_ready got %b want 1", c1_ready); end
        step;
        c1_valid = 1'b0;
        n_checks++; if (o1_valid !== 1'b1 || o1_outs !== 17'h1EFF2 || o1_last !== 1'b1) begin n_fail++; $display("FAIL t1_beat got v=%b d=%h l=%b want 1 1eff2 1", o1_valid, o1_outs, o1_last); end
        step;
        n_checks++; if (o1_valid !== 1'b0 || o1_last !== 1'b0) begin n_fail++; $display("FAIL t1_after got v=%b l=%b want 0 0", o1_valid, o1_last); end
    endtask

    task automatic test_burst_wrap;
        c2_valid = 1'b1; o2_ready = 1'b1;
        step;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) c2_valid = 1'b0;
            n_checks++; if (o2_valid !== 1'b1 || o2_outs !== exp2[i]) begin n_fail++; $display("FAIL t2_beat%0d got v=%b d=%h want 1 %h", i, o2_valid, o2_outs, exp2[i]); end
            n_checks++; if (o2_last !== (i == 3) || c2_ready !== (i == 3)) begin n_fail++; $display("FAIL t2_last_rdy%0d got l=%b r=%b want %b", i, o2_last, c2_ready, (i == 3)); end
            step;
        end
        n_checks++; if (o2_valid !== 1'b0) begin n_fail++; $display("FAIL t2_end got v=%b want 0", o2_valid); end
    endtask

    task automatic test_back_to_back;
        int acc;
        acc = 0;
        c2_valid = 1'b1; o2_ready = 1'b1;
        step;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (o2_valid !== 1'b1 || o2_outs !== exp2[i % 4] || o2_last !== (i % 4 == 3)) begin n_fail++; $display("FAIL t3_beat%0d got v=%b d=%h l=%b want 1 %h %b", i, o2_valid, o2_outs, o2_last, exp2[i % 4], (i % 4 == 3)); end
            if (c2_ready) acc++;
            if (i == 11) c2_valid = 1'b0;
            step;
        end
        n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL t3_accepts got %0d want 3", acc); end
        n_checks++; if (o2_valid !== 1'b0) begin n_fail++; $display("FAIL t3_end got v=%b want 0", o2_valid); end
    endtask

    task automatic test_stall;
        mon4 = 1'b1;
        c4_valid = 1'b1; o4_ready = 1'b1;
        step;
        c4_valid = 1'b0;
        n_checks++; if (o4_valid !== 1'b1 || o4_outs !== 8'h10 || o4_last !== 1'b0) begin n_fail++; $display("FAIL t4_beat0 got v=%b d=%h l=%b want 1 10 0", o4_valid, o4_outs, o4_last); end
        step;
        for (int i = 0; i < 3; i++) begin
            o4_ready = (i == 2);
            n_checks++; if (o4_valid !== 1'b1 || o4_outs !== 8'h13 || o4_last !== 1'b0) begin n_fail++; $display("FAIL t4_hold%0d got v=%b d=%h l=%b want 1 13 0", i, o4_valid, o4_outs, o4_last); end
            n_checks++; if (c4_ready !== 1'b0) begin n_fail++; $display("FAIL t4_cready%0d got %b want 0", i, c4_ready); end
            step;
        end
        n_checks++; if (o4_valid !== 1'b1 || o4_outs !== 8'h16 || o4_last !== 1'b1) begin n_fail++; $display("FAIL t4_beat2 got v=%b d=%h l=%b want 1 16 1", o4_valid, o4_outs, o4_last); end
        step; step;
        mon4 = 1'b0;
        n_checks++; if (o4_valid !== 1'b0 || beats4 !== 3) begin n_fail++; $display("FAIL t4_total got v=%b beats=%0d want 0 3", o4_valid, beats4); end
    endtask

    task automatic test_async_reset;
        c2_valid = 1'b1; o2_ready = 1'b1;
        step;
        c2_valid = 1'b0;
        n_checks++; if (o2_outs !== 8'hFE) begin n_fail++; $display("FAIL t5_beat0 got %h want fe", o2_outs); end
        step;
        n_checks++; if (o2_outs !== 8'hFF) begin n_fail++; $display("FAIL t5_beat1 got %h want ff", o2_outs); end
        #3 rst = 1'b1;
        #1;
        n_checks++; if (o2_valid !== 1'b0 || o2_outs !== 8'h00 || o2_last !== 1'b0) begin n_fail++; $display("FAIL t5_async got v=%b d=%h l=%b want 0 00 0", o2_valid, o2_outs, o2_last); end
        c2_valid = 1'b1;
        step;
        n_checks++; if (o2_valid !== 1'b0) begin n_fail++; $display("FAIL t5_in_reset got v=%b want 0", o2_valid); end
        step;
        rst = 1'b0;
        step;
        c2_valid = 1'b0;
        n_checks++; if (o2_valid !== 1'b1 || o2_outs !== 8'hFE) begin n_fail++; $display("FAIL t5_restart got v=%b d=%h want 1 fe", o2_valid, o2_outs); end
        step; step; step;
        n_checks++; if (o2_outs !== 8'h01 || o2_last !== 1'b1) begin n_fail++; $display("FAIL t5_last got d=%h l=%b want 01 1", o2_outs, o2_last); end
        step;
        n_checks++; if (o2_valid !== 1'b0) begin n_fail++; $display("FAIL t5_end got v=%b want 0", o2_valid); end
    endtask

    task automatic test_random;
        mon6 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            c1_valid = 1'($urandom_range(0, 1));
            o1_ready = 1'($urandom_range(0, 1));
            step;
        end
        c1_valid = 1'b0; o1_ready = 1'b1;
        step; step;
        mon6 = 1'b0;
        n_checks++; if (acc6 !== beats6) begin n_fail++; $display("FAIL t6_count got beats=%0d want %0d", beats6, acc6); end
        n_checks++; if (bad6 !== 0) begin n_fail++; $display("FAIL t6_value got bad=%0d want 0", bad6); end
        n_checks++; if (acc6 < 100) begin n_fail++; $display("FAIL t6_activity got accepts=%0d want >=100", acc6); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst_wrap;
        test_back_to_back;
        test_stall;
        test_async_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
